// File: rtl/cross_product_pipe_pkg.sv
// Shared configuration for the cross-product unit.
// All instances derive their widths from the point-cloud width.
package cross_product_pipe_pkg;

  localparam int CLOUD_BW         = 24;
  localparam int CROSS_IN_BW      = CLOUD_BW;
  localparam int CROSS_MUL_STAGES = 2;
  localparam int CROSS_OUT_SHIFT  = 0;
  localparam int CROSS_OUT_BW     = 2 * CLOUD_BW + 1;

endpackage

// File: rtl/cross_product_pipe_if.sv
// Operand/result handshake bundle of the cross-product unit.
// slave is the unit side, master the producer/consumer side.
interface cross_product_pipe_if #(
  parameter int IN_BW  = 24,
  parameter int OUT_BW = 49
);
  logic                     i_valid;
  logic                     o_ready;
  logic signed [IN_BW-1:0]  i_p0_x;
  logic signed [IN_BW-1:0]  i_p0_y;
  logic signed [IN_BW-1:0]  i_p0_z;
  logic signed [IN_BW-1:0]  i_p1_x;
  logic signed [IN_BW-1:0]  i_p1_y;
  logic signed [IN_BW-1:0]  i_p1_z;
  logic                     o_valid;
  logic                     i_ready;
  logic signed [OUT_BW-1:0] o_normal_x;
  logic signed [OUT_BW-1:0] o_normal_y;
  logic signed [OUT_BW-1:0] o_normal_z;
  logic                     o_sat;
  logic                     o_degenerate;

  modport slave (
    input  i_valid, i_ready,
    input  i_p0_x, i_p0_y, i_p0_z,
    input  i_p1_x, i_p1_y, i_p1_z,
    output o_ready, o_valid,
    output o_normal_x, o_normal_y, o_normal_z,
    output o_sat, o_degenerate
  );

  modport master (
    output i_valid, i_ready,
    output i_p0_x, i_p0_y, i_p0_z,
    output i_p1_x, i_p1_y, i_p1_z,
    input  o_ready, o_valid,
    input  o_normal_x, o_normal_y, o_normal_z,
    input  o_sat, o_degenerate
  );
endinterface

// File: rtl/signed_mult_pipe.sv
// Signed full-precision multiplier with STAGES pipeline registers.
// The enable freezes every stage so the caller can stall.
module signed_mult_pipe #(
  parameter int IN_BW  = 24,
  parameter int STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic signed [IN_BW-1:0]   a,
  input  logic signed [IN_BW-1:0]   b,
  output logic signed [2*IN_BW-1:0] p
);

  logic signed [2*IN_BW-1:0] pipe [STAGES];

  // first stage captures the product, the rest are retiming registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
    end else if (en) begin
      pipe[0] <= a * b;
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign p = pipe[STAGES-1];

endmodule

// File: rtl/cross_product_pipe.sv
// Back-pressurable 3D cross product n = p0 x p1 with
// output scaling, saturation and a collinear flag.
module cross_product_pipe
  import cross_product_pipe_pkg::*;
#(
  parameter int IN_BW      = CROSS_IN_BW,
  parameter int MUL_STAGES = CROSS_MUL_STAGES,
  parameter int OUT_SHIFT  = CROSS_OUT_SHIFT,
  parameter int OUT_BW     = CROSS_OUT_BW
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  input logic                 i_flush,
  cross_product_pipe_if.slave bus
);

  localparam int PW = 2 * IN_BW;
  localparam int DW = PW + 1;

  logic                     en;
  logic [MUL_STAGES:0]      vld_q;
  logic signed [IN_BW-1:0]  ma   [6];
  logic signed [IN_BW-1:0]  mb   [6];
  logic signed [PW-1:0]     prod [6];
  logic signed [DW-1:0]     diff [3];
  logic signed [DW-1:0]     shf  [3];
  logic signed [OUT_BW-1:0] nrm  [3];
  logic signed [OUT_BW-1:0] nrm_q [3];
  logic [2:0]               clip;
  logic                     deg;
  logic                     sat_q;
  logic                     deg_q;

  assign en          = ~vld_q[MUL_STAGES] | bus.i_ready;
  assign bus.o_ready = en;
  assign bus.o_valid = vld_q[MUL_STAGES];

  assign ma[0] = bus.i_p0_y;
  assign mb[0] = bus.i_p1_z;
  assign ma[1] = bus.i_p0_z;
  assign mb[1] = bus.i_p1_y;
  assign ma[2] = bus.i_p0_z;
  assign mb[2] = bus.i_p1_x;
  assign ma[3] = bus.i_p0_x;
  assign mb[3] = bus.i_p1_z;
  assign ma[4] = bus.i_p0_x;
  assign mb[4] = bus.i_p1_y;
  assign ma[5] = bus.i_p0_y;
  assign mb[5] = bus.i_p1_x;

  for (genvar k = 0; k < 6; k++) begin : g_mul
    signed_mult_pipe #(
      .IN_BW  (IN_BW),
      .STAGES (MUL_STAGES)
    ) u_mul (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .en    (en),
      .a     (ma[k]),
      .b     (mb[k]),
      .p     (prod[k])
    );
  end

  // one extra bit keeps the difference exact for full-scale operands
  for (genvar k = 0; k < 3; k++) begin : g_diff
    assign diff[k] = $signed({prod[2*k][PW-1], prod[2*k]})
                   - $signed({prod[2*k+1][PW-1], prod[2*k+1]});
    assign shf[k]  = diff[k] >>> OUT_SHIFT;
  end

  assign deg = (diff[0] == '0) && (diff[1] == '0) && (diff[2] == '0);

  if (OUT_BW < DW) begin : g_sat
    localparam logic signed [DW-1:0] HI =
      $signed({{(DW-OUT_BW+1){1'b0}}, {(OUT_BW-1){1'b1}}});
    localparam logic signed [DW-1:0] LO =
      $signed({{(DW-OUT_BW+1){1'b1}}, {(OUT_BW-1){1'b0}}});

    // clip each shifted difference into the output range
    always_comb begin
      clip = '0;
      for (int k = 0; k < 3; k++) begin
        nrm[k] = shf[k][OUT_BW-1:0];
        if (shf[k] > HI) begin
          nrm[k]  = {1'b0, {(OUT_BW-1){1'b1}}};
          clip[k] = 1'b1;
        end else if (shf[k] < LO) begin
          nrm[k]  = {1'b1, {(OUT_BW-1){1'b0}}};
          clip[k] = 1'b1;
        end
      end
    end
  end else begin : g_ext
    // output is wide enough: sign-extend, never clip
    always_comb begin
      clip = '0;
      for (int k = 0; k < 3; k++) begin
        nrm[k] = OUT_BW'(shf[k]);
      end
    end
  end

  // valid chain: flush clears it, otherwise it moves with en
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q <= '0;
    end else if (i_flush) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q <= {vld_q[MUL_STAGES-1:0], bus.i_valid};
    end
  end

  // result register: subtract/shift/saturate stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 3; k++) nrm_q[k] <= '0;
      sat_q <= 1'b0;
      deg_q <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < 3; k++) nrm_q[k] <= nrm[k];
      sat_q <= |clip;
      deg_q <= deg;
    end
  end

  assign bus.o_normal_x   = nrm_q[0];
  assign bus.o_normal_y   = nrm_q[1];
  assign bus.o_normal_z   = nrm_q[2];
  assign bus.o_sat        = sat_q;
  assign bus.o_degenerate = deg_q;

endmodule
